rc5_key_sched_ctrl: RTL and testbench
=====================================

Name: rc5_key_sched_ctrl

Overview:
Sequences the complete RC5 key expansion: it loads the secret key into L words, initialises the S table with the P/Q magic constants, then runs the 3*max(t,c) mixing loop. It owns the S and L register files and holds the expanded S table for the encrypt/decrypt round cores. The round cores read S through a combinational read port. It sits between the key input and the round datapath, and replaces the ad-hoc keyBytesToWords sequencing.

Parameters:
W, 32, word width in bits (power of two).
B, 16, key length in bytes.
C, 4, number of L words (B*8/W).
T, 26, number of S words (2*rounds+2).
P_W, 32'hB7E15163, RC5 magic P.
Q_W, 32'h9E3779B9, RC5 magic Q.
MIX_ITERS, 78, mixing iterations (3*max(T,C)). Overridable for test only.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request a new expansion. Sampled only in IDLE or DONE.
key  input  8*B  secret key. Byte k = key[8k+7:8k]. Sampled in LOAD only.
busy  output  1  high in LOAD, INIT, MIX.
key_ready  output  1  S table valid. Level, high in DONE.
s_addr  input  clog2(T)  S read address.
s_data  output  W  S[s_addr], combinational. Returns 0 for s_addr >= T.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0; key_ready=0.
  - All S, L, A, B registers, index i (0..T-1), index j (0..C-1) and iteration counter k cleared to 0.
  - Reset mid-operation aborts immediately. No partial result is flagged valid.
- States:
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle):
    - L[j] <= key[W*j+W-1 : W*j], i.e. little-endian bytes per word.
    - S[0] <= P_W; i <= 1; A <= 0; B <= 0.
    - Next state: INIT.
  - INIT (T-1 cycles): S[i] <= S[i-1] + Q_W (mod 2^W); i++. Once S[T-1] is written: i<=0, j<=0, k<=0, go to MIX.
  - MIX (MIX_ITERS cycles, one iteration per cycle):
    - A' = rotl(S[i]+A+B, 3); B' = rotl(L[j]+A'+B, (A'+B) mod W).
    - Write S[i]<=A', L[j]<=B', A<=A', B<=B'.
    - i wraps T-1 -> 0; j wraps C-1 -> 0 (independent wraps).
    - k++. On the iteration with k=MIX_ITERS-1, go to DONE.
  - DONE: key_ready=1, busy=0.
    - start=1 -> LOAD. key_ready drops on that same edge.
    - The S table holds until then.
- Arithmetic: all additions are modulo 2^W. Rotation amount uses the low log2(W) bits only.
- Latency, with edge 0 the edge that samples start:
  - LOAD at edge 1; INIT at edges 2..T.
  - MIX at edges T+1..T+MIX_ITERS.
  - key_ready=1 after edge T+MIX_ITERS. Default: 104 cycles.
- busy and key_ready are never both 1. Both are registered.
- start while busy is ignored; no queueing.
- key changes after LOAD have no effect on the run in progress.
- s_data is readable at any time, but is only guaranteed meaningful while key_ready=1. During busy it shows in-progress contents.
- Reads and writes to the same S entry in one cycle: s_data shows the pre-edge value.

Test Plan:
1. Reset then idle: rst low for 2 cycles, start=0 for 20 cycles -> busy=0, key_ready=0, s_data=0 for every s_addr 0..25.
2. Timing, zero key, defaults: start pulse -> busy rises after edge 1, key_ready rises exactly 104 cycles after the start edge, busy falls the same edge. Read S[0..25] and compare to a software RC5-32/12/16 reference model.
3. Single mix iteration, MIX_ITERS=1, key=0 -> after key_ready: S[0]=32'hBF0A8B1D, S[1]=32'h5618CB1C, S[2]=32'hF45044D5, S[25]=P_W+25*Q_W mod 2^32.
4. Non-trivial key, key=128'hFFFEEEE58684FFF05FFE493853000434 -> all 26 S words match the reference model. Start pulses during busy cause no restart; total latency stays 104.
5. Re-key from DONE: second start with a different key -> key_ready low on the next edge, high again 104 cycles later, and S matches the new key's model.
6. Reset mid-MIX: rst low at cycle 50 -> busy and key_ready go 0 immediately (asynchronously). A following start yields the correct S table with fresh 104-cycle latency.

Source files
------------

// File: rtl/rc5_key_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rc5_key_sched_ctrl
// Description : RC5 key expansion sequencer. Owns the S/L tables and
//               exposes the expanded S table through a combinational read port.
// Revision    : 1.0  initial release
// ============================================================================
module rc5_key_sched_ctrl #(
    parameter int         W         = 32,
    parameter int         B         = 16,
    parameter int         C         = 4,
    parameter int         T         = 26,
    parameter logic [W-1:0] P_W     = 32'hB7E15163,
    parameter logic [W-1:0] Q_W     = 32'h9E3779B9,
    parameter int         MIX_ITERS = 78
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*B-1:0]       key,
    output logic                 busy,
    output logic                 key_ready,
    input  logic [$clog2(T)-1:0] s_addr,
    output logic [W-1:0]         s_data
);

    localparam int IW = $clog2(T);
    localparam int JW = (C > 1) ? $clog2(C) : 1;
    localparam int KW = $clog2(MIX_ITERS + 1);
    localparam int RW = $clog2(W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_INIT = 3'd2,
        ST_MIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            busy_next, ready_next;
    logic [W-1:0]    s_mem [T];
    logic [W-1:0]    l_mem [C];
    logic [W-1:0]    mix_a, mix_b;
    logic [W-1:0]    a_new, b_new, ab_sum;
    logic [IW-1:0]   idx_i;
    logic [JW-1:0]   idx_j;
    logic [KW-1:0]   iter_k;

    // Double-width shift keeps rotation by zero well defined.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= busy_next;
            key_ready <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_INIT;
            ST_INIT: if (idx_i == IW'(T - 1)) state_next = ST_MIX;
            ST_MIX:  if (iter_k == KW'(MIX_ITERS - 1)) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
        busy_next  = (state_next == ST_LOAD) || (state_next == ST_INIT) || (state_next == ST_MIX);
        ready_next = (state_next == ST_DONE);
    end

    always_comb begin
        a_new  = rotl(s_mem[idx_i] + mix_a + mix_b, RW'(3));
        ab_sum = a_new + mix_b;
        b_new  = rotl(l_mem[idx_j] + ab_sum, ab_sum[RW-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < T; n++) s_mem[n] <= '0;
            for (int n = 0; n < C; n++) l_mem[n] <= '0;
            mix_a  <= '0;
            mix_b  <= '0;
            idx_i  <= '0;
            idx_j  <= '0;
            iter_k <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    for (int n = 0; n < C; n++) l_mem[n] <= key[W*n +: W];
                    s_mem[0] <= P_W;
                    idx_i    <= IW'(1);
                    mix_a    <= '0;
                    mix_b    <= '0;
                end
                ST_INIT: begin
                    s_mem[idx_i] <= s_mem[idx_i - IW'(1)] + Q_W;
                    if (idx_i == IW'(T - 1)) begin
                        idx_i  <= '0;
                        idx_j  <= '0;
                        iter_k <= '0;
                    end else begin
                        idx_i <= idx_i + IW'(1);
                    end
                end
                ST_MIX: begin
                    s_mem[idx_i] <= a_new;
                    l_mem[idx_j] <= b_new;
                    mix_a        <= a_new;
                    mix_b        <= b_new;
                    idx_i        <= (idx_i == IW'(T - 1)) ? '0 : idx_i + IW'(1);
                    idx_j        <= (idx_j == JW'(C - 1)) ? '0 : idx_j + JW'(1);
                    iter_k       <= iter_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // Out-of-range addresses read as zero rather than aliasing.
    assign s_data = ({1'b0, s_addr} < (IW+1)'(T)) ? s_mem[s_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rc5_key_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rc5_key_sched_ctrl
// Description : Scoreboard bench for rc5_key_sched_ctrl against an RC5 model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rc5_key_sched_ctrl;

    localparam int T = 26;
    localparam logic [31:0] P = 32'hB7E15163;
    localparam logic [31:0] Q = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, start1;
    logic [127:0] key0, key1;
    logic [4:0]   addr0, addr1;
    logic         busy0, rdy0, busy1, rdy1;
    logic [31:0]  data0, data1;

    always #5 clk = ~clk;

    rc5_key_sched_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .key(key0),
        .busy(busy0), .key_ready(rdy0), .s_addr(addr0), .s_data(data0)
    );

    rc5_key_sched_ctrl #(.MIX_ITERS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key(key1),
        .busy(busy1), .key_ready(rdy1), .s_addr(addr1), .s_data(data1)
    );

    // src: 0 data0, 1 busy0, 2 rdy0, 3 data1, 4 busy1, 5 rdy1, 6 latency
    typedef struct {
        int          src;
        logic [31:0] exp;
        logic [31:0] act;
        int          tag;
    } item_t;

    item_t       sb_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] ref_s [T];

    function automatic string src_name(input int s);
        case (s)
            0: return "s_data0";
            1: return "busy0";
            2: return "key_ready0";
            3: return "s_data1";
            4: return "busy1";
            5: return "key_ready1";
            default: return "latency";
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = sb_q.pop_front();
            case (it.src)
                0: act = data0;
                1: act = {31'b0, busy0};
                2: act = {31'b0, rdy0};
                3: act = data1;
                4: act = {31'b0, busy1};
                5: act = {31'b0, rdy1};
                default: act = it.act;
            endcase
            compared++;
            if (act !== it.exp) begin
                mismatched++;
                $display("FAIL %s tag=%0d actual=%h required=%h", src_name(it.src), it.tag, act, it.exp);
            end
        end
        if (rst === 1'b1) begin
            compared++;
            if ((busy0 && rdy0) || (busy1 && rdy1)) begin
                mismatched++;
                $display("FAIL busy_and_ready actual=%b%b/%b%b required=not both", busy0, rdy0, busy1, rdy1);
            end
        end
    end

    task automatic expect_out(input int src, input logic [31:0] exp, input int tag);
        sb_q.push_back('{src: src, exp: exp, act: 32'h0, tag: tag});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Textbook RC5 key expansion.
    task automatic compute_ref(input logic [127:0] k, input int iters);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int n = 0; n < 4; n++) l[n] = k[32*n +: 32];
        ref_s[0] = P;
        for (int n = 1; n < T; n++) ref_s[n] = ref_s[n-1] + Q;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < iters; n++) begin
            a        = rol(ref_s[i] + a + b, 3);
            ref_s[i] = a;
            b        = rol(l[j] + a + b, int'((a + b) & 32'd31));
            l[j]     = b;
            i        = (i + 1) % T;
            j        = (j + 1) % 4;
        end
    endtask

    task automatic check_table(input int dsel);
        for (int a = 0; a < 32; a++) begin
            tick();
            if (dsel == 0) addr0 = 5'(a); else addr1 = 5'(a);
            expect_out(dsel == 0 ? 0 : 3, (a < T) ? ref_s[a] : 32'h0, a);
        end
        tick();
    endtask

    task automatic run(input int dsel, input logic [127:0] k, input int exp_lat,
                       input bit pulse_mid, input int abort_at);
        int lat;
        lat = -1;
        tick();
        if (dsel == 0) begin key0 = k; start0 = 1'b1; end
        else           begin key1 = k; start1 = 1'b1; end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (pulse_mid) begin
                start0 = (n == 30 || n == 60);
                if (n == 40) key0 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (n == 1) begin
                expect_out(dsel == 0 ? 1 : 4, 32'd1, n);
                expect_out(dsel == 0 ? 2 : 5, 32'd0, n);
            end
            if (n == abort_at) begin
                rst = 1'b0;
                #1;
                expect_out(1, 32'd0, n);
                expect_out(2, 32'd0, n);
                expect_out(4, 32'd0, n);
                expect_out(0, 32'd0, n);
                @(negedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            if ((dsel == 0 ? rdy0 : rdy1) === 1'b1) begin
                lat = n;
                expect_out(dsel == 0 ? 1 : 4, 32'd0, n);
                break;
            end
        end
        start0 = 1'b0;
        sb_q.push_back('{src: 6, exp: 32'(exp_lat), act: 32'(lat), tag: dsel});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        key0 = '0; key1 = '0; addr0 = '0; addr1 = '0;
        repeat (2) tick();
        rst = 1'b1;

        // Idle after reset: outputs quiet and both tables read zero.
        for (int n = 0; n < 20; n++) begin
            tick();
            expect_out(1, 32'd0, n);
            expect_out(2, 32'd0, n);
        end
        for (int n = 0; n < T; n++) ref_s[n] = '0;
        check_table(0);
        check_table(1);

        // Zero key, full schedule.
        compute_ref('0, 78);
        run(0, '0, 104, 1'b0, 0);
        check_table(0);

        // Single mix iteration, known constants.
        compute_ref('0, 1);
        run(1, '0, 27, 1'b0, 0);
        check_table(1);
        tick(); addr1 = 5'd0;  expect_out(3, 32'hBF0A8B1D, 100);
        tick(); addr1 = 5'd1;  expect_out(3, 32'h5618CB1C, 101);
        tick(); addr1 = 5'd2;  expect_out(3, 32'hF45044D5, 102);
        tick(); addr1 = 5'd25; expect_out(3, P + 32'd25 * Q, 125);

        // Fixed key, spurious starts and key changes mid-run.
        k = 128'hFFFEEEE58684FFF05FFE493853000434;
        compute_ref(k, 78);
        run(0, k, 104, 1'b1, 0);
        check_table(0);

        // Re-key from DONE with random keys.
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            compute_ref(k, 78);
            run(0, k, 104, 1'b0, 0);
            check_table(0);
        end

        // Abort during MIX, then a clean run.
        run(0, {$urandom, $urandom, $urandom, $urandom}, 104, 1'b0, 50);
        for (int n = 0; n < T; n++) ref_s[n] = '0;
        check_table(0);
        k = {$urandom, $urandom, $urandom, $urandom};
        compute_ref(k, 78);
        run(0, k, 104, 1'b0, 0);
        check_table(0);

        k = {$urandom, $urandom, $urandom, $urandom};
        compute_ref(k, 1);
        run(1, k, 27, 1'b0, 0);
        check_table(1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
